ins_sequencer: RTL
==================

Name: ins_sequencer

Overview:
- Main CPU control FSM; sits directly upstream of the instruction decoder and closes the loop with it.
- Fetches opcodes and operand bytes from ROM, holds the instruction and data registers, and owns the run_phase counter.
- Executes the decoder's next_status requests (ROM read, RAM read, ALU process, RAM write, NOP) and returns to fetch when the instruction completes.

Parameters:
- PC_W, 16, program counter / ROM address width.
- RESET_PC, 16'h0000, PC value after reset.
- ACK_TIMEOUT, 15, cycles to wait for a memory ack before abort (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- next_status  in  3  decoder request: NOP=000, RAM_READ=001, ROM_READ=010, PROCESS=011, RAM_WRITE=100, INS_DECODE=101, NOT_DONE=111.
- run_phase_init  in  3  decoder phase count for the current instruction.
- addr_register_in  in  8  decoder RAM address.
- a_data_from  in  3  write-data select: A=000, RAM_DATA_REG=001, ROM_DATA_REG=010.
- acc  in  8  accumulator value.
- alu_result  in  8  ALU output.
- instruction  out  8  instruction register.
- run_phase  out  3  current phase.
- rom_data_register  out  8  last operand byte.
- ram_data_register  out  8  last RAM read or ALU result.
- rom_req  out  1  ROM read request.
- rom_addr  out  PC_W  ROM address.
- rom_ack  in  1  ROM data valid.
- rom_rdata  in  8  ROM data.
- ram_req  out  1  RAM request.
- ram_we  out  1  1 = write.
- ram_addr  out  8  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_ack  in  1  RAM done / read data valid.
- ram_rdata  in  8  RAM read data.
- illegal_ins  out  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- Reset: state=FETCH, pc=RESET_PC. All of instruction, run_phase, both data registers, rom_req, ram_req, ram_we, ram_addr, ram_wdata and illegal_ins are 0.
- States: FETCH, LOAD, DISPATCH, ROM_RD, RAM_RD, PROC, RAM_WR.
- FETCH:
  - rom_req=1, rom_addr=pc.
  - On rom_ack: instruction<=rom_rdata, pc<=pc+1 (wraps modulo 2^PC_W), go to LOAD.
- LOAD (1 cycle): run_phase<=run_phase_init, go to DISPATCH.
- DISPATCH, checked in priority order:
  - next_status=INS_DECODE or NOT_DONE: pulse illegal_ins, go to FETCH.
  - next_status=NOP: go to FETCH.
  - run_phase==0: go to FETCH. This covers single-phase instructions and init=0.
  - Otherwise: 001 goes to RAM_RD, 010 to ROM_RD, 011 to PROC, 100 to RAM_WR.
- ROM_RD:
  - rom_req=1, rom_addr=pc.
  - On rom_ack: rom_data_register<=rom_rdata, pc<=pc+1.
- RAM_RD:
  - ram_req=1, ram_we=0, ram_addr=addr_register_in.
  - On ram_ack: ram_data_register<=ram_rdata.
- RAM_WR:
  - ram_req=1, ram_we=1, ram_addr=addr_register_in.
  - ram_wdata selected by a_data_from: acc, ram_data_register or rom_data_register; any other code gives 8'h00.
  - Completes on ram_ack.
- PROC: ram_data_register<=alu_result; always completes in 1 cycle.
- On completion of any op: run_phase<=run_phase-1, then return to DISPATCH. If the decrement reaches 0, the next DISPATCH goes to FETCH.
- Request and address/data outputs hold stable until ack. Ack arriving in the same cycle as the request completes the op that cycle.
- An ack seen outside the matching state is ignored.
- rom_req and ram_req are never asserted together.
- Reset mid-operation: asynchronous return to reset values; any in-flight memory access is abandoned.

Optional Feature:
- Macro SEQ_ACK_WATCHDOG_EN.
- When defined: a counter runs in FETCH, ROM_RD, RAM_RD and RAM_WR and clears on ack or state change. After ACK_TIMEOUT cycles without ack:
  - drop the request;
  - pulse illegal_ins;
  - set run_phase=0 and go to FETCH;
  - leave pc unchanged, so the fetch retries the same address.
- When undefined: the FSM waits for ack indefinitely; no counter logic exists.

Decomposition:
- Shared package cpu_pkg holds:
  - next_status codes;
  - data-source codes;
  - state enum;
  - widths: 8-bit data, 3-bit phase.
- Sub-module: seq_wdata_mux, the combinational a_data_from write-data select. Everything else stays in ins_sequencer.

Test Plan:
- Reset release with ROM[0]=8'h00 (NOP): fetch at 0, instruction=00, DISPATCH then FETCH at pc=1; no RAM access.
- Opcode F5, init=2, ROM[1]=8'h30, acc=8'h5A; decoder gives ROM_READ then RAM_WRITE addr 30 from A → RAM write 30<=5A, run_phase 2→1→0, next fetch at pc=2.
- INC-style sequence, init=3, RAM[08]=8'h7F, alu_result=8'h80: RAM_RD, then PROC, then RAM_WR with source RAM_DATA_REG → RAM write 08<=80.
- next_status=INS_DECODE on opcode A5 → illegal_ins pulses exactly 1 cycle; next fetch at the following pc.
- rom_ack delayed 5 cycles → rom_req and rom_addr held stable for all 5 cycles, pc increments once only; with the watchdog enabled and ACK_TIMEOUT=3 → abort, retry at the same pc.
- rst_n low mid-RAM_WR → ram_req=0 and state=FETCH immediately; after release, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: decoder request codes, write-data sources, sequencer states, datapath widths.
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned PHASE_W = 3;
  localparam int unsigned RAM_AW  = 8;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [2:0] {
    NS_NOP        = 3'b000,
    NS_RAM_READ   = 3'b001,
    NS_ROM_READ   = 3'b010,
    NS_PROCESS    = 3'b011,
    NS_RAM_WRITE  = 3'b100,
    NS_INS_DECODE = 3'b101,
    NS_NOT_DONE   = 3'b111
  } next_status_e;

  typedef enum logic [2:0] {
    SRC_A            = 3'b000,
    SRC_RAM_DATA_REG = 3'b001,
    SRC_ROM_DATA_REG = 3'b010
  } data_src_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LOAD,
    ST_DISPATCH,
    ST_ROM_RD,
    ST_RAM_RD,
    ST_PROC,
    ST_RAM_WR
  } seq_state_e;

  // Codes the decoder cannot turn into an operation (3'b110 is unassigned).
  function automatic logic is_illegal_status(input logic [2:0] ns);
    return (ns == NS_INS_DECODE) || (ns == NS_NOT_DONE) || (ns == 3'b110);
  endfunction

endpackage

// File: rtl/seq_wdata_mux.sv
// RAM write-data source select driven by the decoder's a_data_from code.
module seq_wdata_mux
  import cpu_pkg::*;
(
  input  logic [2:0] sel_i,
  input  data_t      acc_i,
  input  data_t      ram_data_i,
  input  data_t      rom_data_i,
  output data_t      wdata_o_c
);

  always_comb begin
    wdata_o_c = '0;
    case (sel_i)
      SRC_A:            wdata_o_c = acc_i;
      SRC_RAM_DATA_REG: wdata_o_c = ram_data_i;
      SRC_ROM_DATA_REG: wdata_o_c = rom_data_i;
      default:          wdata_o_c = '0;
    endcase
  end

endmodule

// File: rtl/ins_sequencer.sv
// Main CPU control FSM: fetches opcodes/operands, runs decoder-requested phases.
// Optional macro SEQ_ACK_WATCHDOG_EN adds an ack timeout that aborts to fetch.
module ins_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int unsigned     ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         next_status,
  input  logic [PHASE_W-1:0] run_phase_init,
  input  logic [RAM_AW-1:0]  addr_register_in,
  input  logic [2:0]         a_data_from,
  input  logic [DATA_W-1:0]  acc,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  instruction,
  output logic [PHASE_W-1:0] run_phase,
  output logic [DATA_W-1:0]  rom_data_register,
  output logic [DATA_W-1:0]  ram_data_register,
  output logic               rom_req,
  output logic [PC_W-1:0]    rom_addr,
  input  logic               rom_ack,
  input  logic [DATA_W-1:0]  rom_rdata,
  output logic               ram_req,
  output logic               ram_we,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic               ram_ack,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic               illegal_ins
);

  if (ACK_TIMEOUT == 0) begin : g_bad_ack_timeout
    $error("ACK_TIMEOUT must be at least 1");
  end

  seq_state_e        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  data_t             instr_q, instr_d;
  phase_t            phase_q, phase_d;
  data_t             rom_dreg_q, rom_dreg_d;
  data_t             ram_dreg_q, ram_dreg_d;
  logic              rom_req_q, rom_req_d;
  logic [PC_W-1:0]   rom_addr_q, rom_addr_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  data_t             ram_wdata_q, ram_wdata_d;
  logic              illegal_q, illegal_d;

  logic              rom_done_c;
  logic              ram_done_c;
  logic              drop_req_c;
  data_t             wdata_c;

  // An ack only counts while our own request is on the bus.
  assign rom_done_c = rom_req_q & rom_ack;
  assign ram_done_c = ram_req_q & ram_ack;

  seq_wdata_mux u_wdata_mux (
    .sel_i      (a_data_from),
    .acc_i      (acc),
    .ram_data_i (ram_dreg_q),
    .rom_data_i (rom_dreg_q),
    .wdata_o_c  (wdata_c)
  );

`ifdef SEQ_ACK_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(ACK_TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wait_state_c;

  assign wait_state_c = (state_q == ST_FETCH)  || (state_q == ST_ROM_RD) ||
                        (state_q == ST_RAM_RD) || (state_q == ST_RAM_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    phase_d     = phase_q;
    rom_dreg_d  = rom_dreg_q;
    ram_dreg_d  = ram_dreg_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    illegal_d   = 1'b0;
    drop_req_c  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (rom_done_c) begin
          instr_d = rom_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        phase_d = run_phase_init;
        state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (is_illegal_status(next_status)) begin
          illegal_d = 1'b1;
          state_d   = ST_FETCH;
        end else if (next_status == NS_NOP) begin
          state_d = ST_FETCH;
        end else if (phase_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          case (next_status)
            NS_RAM_READ: begin
              state_d    = ST_RAM_RD;
              ram_addr_d = addr_register_in;
            end
            NS_ROM_READ: state_d = ST_ROM_RD;
            NS_PROCESS:  state_d = ST_PROC;
            NS_RAM_WRITE: begin
              state_d     = ST_RAM_WR;
              ram_addr_d  = addr_register_in;
              ram_wdata_d = wdata_c;
            end
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_ROM_RD: begin
        if (rom_done_c) begin
          rom_dreg_d = rom_rdata;
          pc_d       = pc_q + PC_W'(1);
          phase_d    = phase_q - PHASE_W'(1);
          state_d    = ST_DISPATCH;
        end
      end
      ST_RAM_RD: begin
        if (ram_done_c) begin
          ram_dreg_d = ram_rdata;
          phase_d    = phase_q - PHASE_W'(1);
          state_d    = ST_DISPATCH;
        end
      end
      ST_PROC: begin
        ram_dreg_d = alu_result;
        phase_d    = phase_q - PHASE_W'(1);
        state_d    = ST_DISPATCH;
      end
      ST_RAM_WR: begin
        if (ram_done_c) begin
          phase_d = phase_q - PHASE_W'(1);
          state_d = ST_DISPATCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase

`ifdef SEQ_ACK_WATCHDOG_EN
    // Abort a stalled access; pc is untouched so the fetch retries the same byte.
    wd_d = '0;
    if (wait_state_c && (rom_req_q || ram_req_q) && !(rom_done_c || ram_done_c)) begin
      if (wd_q == WD_W'(ACK_TIMEOUT - 1)) begin
        state_d    = ST_FETCH;
        phase_d    = '0;
        illegal_d  = 1'b1;
        drop_req_c = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif

    // Requests are registered from the next state so they hold steady until ack.
    rom_req_d  = ~drop_req_c & ((state_d == ST_FETCH) || (state_d == ST_ROM_RD));
    rom_addr_d = pc_d;
    ram_req_d  = ~drop_req_c & ((state_d == ST_RAM_RD) || (state_d == ST_RAM_WR));
    ram_we_d   = ~drop_req_c & (state_d == ST_RAM_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      phase_q     <= '0;
      rom_dreg_q  <= '0;
      ram_dreg_q  <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= RESET_PC;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      phase_q     <= phase_d;
      rom_dreg_q  <= rom_dreg_d;
      ram_dreg_q  <= ram_dreg_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      illegal_q   <= illegal_d;
    end
  end

  assign instruction       = instr_q;
  assign run_phase         = phase_q;
  assign rom_data_register = rom_dreg_q;
  assign ram_data_register = ram_dreg_q;
  assign rom_req           = rom_req_q;
  assign rom_addr          = rom_addr_q;
  assign ram_req           = ram_req_q;
  assign ram_we            = ram_we_q;
  assign ram_addr          = ram_addr_q;
  assign ram_wdata         = ram_wdata_q;
  assign illegal_ins       = illegal_q;

endmodule
